// File: rtl/lsu_mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types for the LSU memory request controller.
//   state_t   - controller FSM states
//   mem_req_t - one buffered request {we, addr, wdata, tag} at default widths
package mem_ctrl_pkg;
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_TAG_W  = 4;
   localparam int DEF_DEPTH  = 4;
   typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;
   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
      logic [DEF_TAG_W-1:0]  tag;
   } mem_req_t;
endpackage

// File: rtl/lsu_mem_ctrl_req_fifo.sv
// req_fifo: in-order request buffer with wrap-around pointers.
//   CLK, RSTn   - clock, asynchronous active-low reset (empties the FIFO)
//   push, din   - write din when not full
//   pop         - drop head when not empty
//   dout        - current head entry
//   count       - occupancy; full/empty flags derived from it
module req_fifo
   import mem_ctrl_pkg::*;
#(
   parameter type T     = mem_req_t,
   parameter int  DEPTH = DEF_DEPTH
) (
   input  logic                   CLK,
   input  logic                   RSTn,
   input  logic                   push,
   input  logic                   pop,
   input  T                       din,
   output T                       dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int PW = $clog2(DEPTH);
   T               mem [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic           do_push, do_pop;
   assign full    = count == (PW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];
   // DEPTH is a power of two, so the pointers wrap by plain overflow
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: buffers LSU load/store requests and issues them one at a time
// to the SRAM wrapper, returning tagged responses to the CDB side.
//   CLK, RSTn                          - clock, asynchronous active-low reset
//   lsu_valid/lsu_ready, lsu_we,
//   lsu_addr, lsu_wdata, lsu_tag       - request input handshake
//   rsp_valid, rsp_we, rsp_tag,
//   rsp_rdata                          - one-cycle response pulse
//   PROC_REQ/MEM_RDY, ADDR, WWE, WWDATA - request to memory wrapper
//   RDATA, VALID                       - read data return
module lsu_mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int TAG_W  = DEF_TAG_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic              lsu_we,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [TAG_W-1:0]  lsu_tag,
   output logic              rsp_valid,
   output logic              rsp_we,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              PROC_REQ,
   input  logic              MEM_RDY,
   output logic [ADDR_W-1:0] ADDR,
   output logic              WWE,
   output logic [DATA_W-1:0] WWDATA,
   input  logic [DATA_W-1:0] RDATA,
   input  logic              VALID
);
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [TAG_W-1:0]  tag;
   } req_t;
   req_t                   head, din;
   logic [$clog2(DEPTH):0] count;
   logic                   full, empty, pop;
   state_t                 state_q, state_d;
   logic [TAG_W-1:0]       tag_q, tag_d;
   logic                   proc_req_d, wwe_d, rsp_valid_d, rsp_we_d;
   logic [ADDR_W-1:0]      addr_d;
   logic [DATA_W-1:0]      wwdata_d, rsp_rdata_d;
   logic [TAG_W-1:0]       rsp_tag_d;
   assign din       = '{we: lsu_we, addr: lsu_addr, wdata: lsu_wdata, tag: lsu_tag};
   assign lsu_ready = ~full;
   req_fifo #(.T(req_t), .DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .push  (lsu_valid),
      .pop   (pop),
      .din   (din),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );
   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q;
      proc_req_d  = PROC_REQ;
      addr_d      = ADDR;
      wwe_d       = WWE;
      wwdata_d    = WWDATA;
      rsp_valid_d = 1'b0;
      rsp_we_d    = rsp_we;
      rsp_tag_d   = rsp_tag;
      rsp_rdata_d = rsp_rdata;
      pop         = 1'b0;
      case (state_q)
         IDLE: if (!empty) begin
            state_d    = REQ;
            proc_req_d = 1'b1;
            addr_d     = head.addr;
            wwe_d      = head.we;
            wwdata_d   = head.wdata;
            tag_d      = head.tag;
         end
         // head stays in the FIFO until the wrapper accepts it
         REQ: if (MEM_RDY) begin
            pop        = 1'b1;
            proc_req_d = 1'b0;
            wwe_d      = 1'b0;
            if (WWE) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_we_d    = 1'b1;
               rsp_tag_d   = tag_q;
               rsp_rdata_d = '0;
            end else begin
               state_d = WAIT_RD;
            end
         end
         WAIT_RD: if (VALID) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_we_d    = 1'b0;
            rsp_tag_d   = tag_q;
            rsp_rdata_d = RDATA;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= IDLE;
         tag_q     <= '0;
         PROC_REQ  <= 1'b0;
         ADDR      <= '0;
         WWE       <= 1'b0;
         WWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_we    <= 1'b0;
         rsp_tag   <= '0;
         rsp_rdata <= '0;
      end else begin
         state_q   <= state_d;
         tag_q     <= tag_d;
         PROC_REQ  <= proc_req_d;
         ADDR      <= addr_d;
         WWE       <= wwe_d;
         WWDATA    <= wwdata_d;
         rsp_valid <= rsp_valid_d;
         rsp_we    <= rsp_we_d;
         rsp_tag   <= rsp_tag_d;
         rsp_rdata <= rsp_rdata_d;
      end
   end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed, table-driven bench for lsu_mem_ctrl.
module tb_lsu_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lsu_valid = 1'b0, lsu_we = 1'b0;
   logic [9:0]  lsu_addr = '0;
   logic [31:0] lsu_wdata = '0;
   logic [3:0]  lsu_tag = '0;
   logic        lsu_ready, rsp_valid, rsp_we, proc_req, wwe;
   logic [3:0]  rsp_tag;
   logic [31:0] rsp_rdata, wwdata;
   logic [9:0]  addr;
   logic        t_rdy = 1'b0, t_valid = 1'b0, auto_mem = 1'b0, mon_en = 1'b0;
   logic [31:0] t_rdata = '0;
   logic        m_valid = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        mem_rdy, valid;
   logic [31:0] rdata;
   logic [31:0] mem [1024];
   int          n_cmp = 0, n_err = 0;
   logic        prev_rv = 1'b0;
   typedef struct packed {
      logic        we;
      logic [3:0]  tag;
      logic [31:0] rdata;
   } rsp_t;
   rsp_t exp_q[$];
   typedef struct {
      logic v, we; logic [9:0] a; logic [31:0] wd; logic [3:0] tg;
      logic rdy, vld; logic [31:0] rd;
      logic e_ready, e_req; logic [9:0] e_addr; logic e_wwe; logic [31:0] e_wwdata;
      logic e_rv, e_rwe; logic [3:0] e_rtag; logic [31:0] e_rdata;
   } vec_t;
   vec_t tv [14];

   assign mem_rdy = t_rdy;
   assign valid   = auto_mem ? m_valid : t_valid;
   assign rdata   = auto_mem ? m_rdata : t_rdata;

   always #5 clk = ~clk;

   lsu_mem_ctrl dut (
      .CLK       (clk),
      .RSTn      (rst_n),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_we    (lsu_we),
      .lsu_addr  (lsu_addr),
      .lsu_wdata (lsu_wdata),
      .lsu_tag   (lsu_tag),
      .rsp_valid (rsp_valid),
      .rsp_we    (rsp_we),
      .rsp_tag   (rsp_tag),
      .rsp_rdata (rsp_rdata),
      .PROC_REQ  (proc_req),
      .MEM_RDY   (mem_rdy),
      .ADDR      (addr),
      .WWE       (wwe),
      .WWDATA    (wwdata),
      .RDATA     (rdata),
      .VALID     (valid)
   );

   // memory wrapper model: stores on accept, read data one cycle after accept
   always @(posedge clk) begin
      m_valid <= 1'b0;
      if (proc_req && mem_rdy) begin
         if (wwe) mem[addr] <= wwdata;
         else begin
            m_valid <= 1'b1;
            m_rdata <= mem[addr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      rsp_t e;
      @(negedge clk);
      if (mon_en) begin
         if (rsp_valid) begin
            chk("rsp_gap", 32'(prev_rv), 0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rsp_unexpected: got tag %h, expected no response", rsp_tag);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_we", 32'(rsp_we), 32'(e.we));
               chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
               chk("rsp_rdata", rsp_rdata, e.rdata);
            end
         end
         prev_rv = rsp_valid;
      end
   endtask

   task automatic push_req(input logic we, input logic [9:0] a, input logic [31:0] d,
                           input logic [3:0] tg, input logic [31:0] erd);
      int n = 0;
      tick();
      lsu_valid = 1'b1; lsu_we = we; lsu_addr = a; lsu_wdata = d; lsu_tag = tg;
      while (!lsu_ready && n < 50) begin
         tick();
         n++;
      end
      chk("push_ready", 32'(lsu_ready), 1);
      @(posedge clk);
      #1 lsu_valid = 1'b0;
      exp_q.push_back('{we: we, tag: tg, rdata: erd});
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 0);
   endtask

   initial begin
      //        v  we a       wd            tg rdy vld rd           | rdy req addr    wwe wwdata        rv rwe tag rdata
      tv[0]  = '{1, 1, 10'h5, 32'hDEADBEEF, 3, 1,  0,  32'h0,         1,  0,  10'h0, 0,  32'h0,         0, 0,  0, 32'h0};
      tv[1]  = '{0, 0, 10'h0, 32'h0,        0, 1,  0,  32'h0,         1,  1,  10'h5, 1,  32'hDEADBEEF,  0, 0,  0, 32'h0};
      tv[2]  = '{0, 0, 10'h0, 32'h0,        0, 1,  0,  32'h0,         1,  0,  10'h0, 0,  32'h0,         1, 1,  3, 32'h0};
      tv[3]  = '{0, 0, 10'h0, 32'h0,        0, 1,  0,  32'h0,         1,  0,  10'h0, 0,  32'h0,         0, 0,  0, 32'h0};
      tv[4]  = '{1, 0, 10'h5, 32'h0,        7, 0,  0,  32'h0,         1,  0,  10'h0, 0,  32'h0,         0, 0,  0, 32'h0};
      tv[5]  = '{0, 0, 10'h0, 32'h0,        0, 0,  0,  32'h0,         1,  1,  10'h5, 0,  32'h0,         0, 0,  0, 32'h0};
      tv[6]  = '{0, 0, 10'h0, 32'h0,        0, 0,  0,  32'h0,         1,  1,  10'h5, 0,  32'h0,         0, 0,  0, 32'h0};
      tv[7]  = '{0, 0, 10'h0, 32'h0,        0, 0,  0,  32'h0,         1,  1,  10'h5, 0,  32'h0,         0, 0,  0, 32'h0};
      tv[8]  = '{0, 0, 10'h0, 32'h0,        0, 1,  0,  32'h0,         1,  0,  10'h0, 0,  32'h0,         0, 0,  0, 32'h0};
      tv[9]  = '{0, 0, 10'h0, 32'h0,        0, 0,  0,  32'h0,         1,  0,  10'h0, 0,  32'h0,         0, 0,  0, 32'h0};
      tv[10] = '{0, 0, 10'h0, 32'h0,        0, 0,  1,  32'hDEADBEEF,  1,  0,  10'h0, 0,  32'h0,         1, 0,  7, 32'hDEADBEEF};
      tv[11] = '{0, 0, 10'h0, 32'h0,        0, 0,  0,  32'h0,         1,  0,  10'h0, 0,  32'h0,         0, 0,  0, 32'h0};
      tv[12] = '{0, 0, 10'h0, 32'h0,        0, 1,  1,  32'h12345678,  1,  0,  10'h0, 0,  32'h0,         0, 0,  0, 32'h0};
      tv[13] = '{0, 0, 10'h0, 32'h0,        0, 1,  1,  32'h12345678,  1,  0,  10'h0, 0,  32'h0,         0, 0,  0, 32'h0};

      // power-on reset values
      repeat (2) @(negedge clk);
      chk("rst_proc_req", 32'(proc_req), 0);
      chk("rst_addr", 32'(addr), 0);
      chk("rst_wwe", 32'(wwe), 0);
      chk("rst_wwdata", wwdata, 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_we", 32'(rsp_we), 0);
      chk("rst_rsp_tag", 32'(rsp_tag), 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_ready", 32'(lsu_ready), 1);
      rst_n = 1'b1;

      // single store, delayed load, spurious VALID / MEM_RDY in IDLE
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         lsu_valid = tv[i].v; lsu_we = tv[i].we; lsu_addr = tv[i].a;
         lsu_wdata = tv[i].wd; lsu_tag = tv[i].tg;
         t_rdy = tv[i].rdy; t_valid = tv[i].vld; t_rdata = tv[i].rd;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ready", i), 32'(lsu_ready), 32'(tv[i].e_ready));
         chk($sformatf("v%0d_proc_req", i), 32'(proc_req), 32'(tv[i].e_req));
         chk($sformatf("v%0d_wwe", i), 32'(wwe), 32'(tv[i].e_wwe));
         chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(tv[i].e_rv));
         if (tv[i].e_req) begin
            chk($sformatf("v%0d_addr", i), 32'(addr), 32'(tv[i].e_addr));
            chk($sformatf("v%0d_wwdata", i), wwdata, tv[i].e_wwdata);
         end
         if (tv[i].e_rv) begin
            chk($sformatf("v%0d_rsp_we", i), 32'(rsp_we), 32'(tv[i].e_rwe));
            chk($sformatf("v%0d_rsp_tag", i), 32'(rsp_tag), 32'(tv[i].e_rtag));
            chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, tv[i].e_rdata);
         end
      end

      // reset while a load waits for VALID, with a second request queued
      tick();
      lsu_valid = 1'b0; t_rdy = 1'b0; t_valid = 1'b0;
      tick();
      lsu_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 10'h9; lsu_wdata = '0; lsu_tag = 4'd5;
      tick();
      lsu_tag = 4'd6;
      tick();
      lsu_valid = 1'b0;
      chk("mid_proc_req", 32'(proc_req), 1);
      t_rdy = 1'b1;
      tick();
      t_rdy = 1'b0;
      chk("mid_accepted", 32'(proc_req), 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(lsu_ready), 1);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("mid_rst_addr", 32'(addr), 0);
      tick();
      tick();
      rst_n = 1'b1;
      t_valid = 1'b1; t_rdata = 32'hCAFEF00D;
      tick();
      t_valid = 1'b0;
      chk("mid_valid_rsp", 32'(rsp_valid), 0);
      chk("mid_valid_rdata", rsp_rdata, 0);
      tick();
      tick();
      chk("mid_post_proc_req", 32'(proc_req), 0);
      chk("mid_post_rsp_valid", 32'(rsp_valid), 0);
      chk("mid_post_rsp_tag", 32'(rsp_tag), 0);
      chk("mid_post_ready", 32'(lsu_ready), 1);
      chk("mid_post_wwdata", wwdata, 0);

      // five back-to-back pushes against a stalled memory
      auto_mem = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < 4; i++)
         push_req(1'b1, 10'(16 + i), 32'h100 + 32'(i), 4'(i), 32'h0);
      tick();
      chk("full_ready", 32'(lsu_ready), 0);
      chk("full_proc_req", 32'(proc_req), 1);
      lsu_valid = 1'b1; lsu_we = 1'b1; lsu_addr = 10'd20; lsu_wdata = 32'h104; lsu_tag = 4'd4;
      tick();
      chk("full_held1", 32'(lsu_ready), 0);
      tick();
      chk("full_held2", 32'(lsu_ready), 0);
      chk("full_addr_stable", 32'(addr), 16);
      t_rdy = 1'b1;
      push_req(1'b1, 10'd20, 32'h104, 4'd4, 32'h0);
      drain();

      // pointer wrap with store/load pairs on the top two words
      for (int p = 0; p < 10; p++) begin
         push_req(1'b1, p[0] ? 10'h3FF : 10'h3FE, 32'hA5A50000 + 32'(p) * 32'h111, 4'(2 * p), 32'h0);
         push_req(1'b0, p[0] ? 10'h3FF : 10'h3FE, 32'h0, 4'(2 * p + 1), 32'hA5A50000 + 32'(p) * 32'h111);
      end
      drain();
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
